// File: rtl/bg_block_ctrl.sv
// Background block cache sequencer: save old block, optionally load new one, then clear pixel state.
// Latency: trigger to IDLE is 2-4 cycles with zero-wait memory; each memory state is held until i_memAck.
// Backpressure: pipeline paused while busy; BGCTRL_SKIP_EMPTY_SAVE_EN skips saves of empty blocks.
module bg_block_ctrl (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_newBlock,
    input  logic [1:0]  i_pairCode,
    input  logic        i_noblend,
    input  logic [14:0] i_saveAdr,
    input  logic [14:0] i_loadAdr,
    input  logic [15:0] i_mask,
    output logic        o_pausePipeline,
    output logic        o_resetPipelinePixelStateSpike,
    output logic        o_resetPixelMask,
    output logic        o_memReq,
    output logic        o_memWrite,
    output logic [14:0] o_memAdr,
    output logic [15:0] o_memMask,
    input  logic        i_memAck,
    output logic        o_importBG,
    output logic        o_flushDone,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAVE  = 2'd1,
        LOAD  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t      state;
    logic        flush_q;
    logic        noblend_q;
    logic [14:0] load_adr_q;
    logic        clear_spike;

    logic        trig_flush;
    logic        trig_save;

    assign trig_flush = (i_pairCode == 2'b11);
`ifdef BGCTRL_SKIP_EMPTY_SAVE_EN
    assign trig_save = i_pairCode[1] && (i_mask != 16'h0000);
`else
    assign trig_save = i_pairCode[1];
`endif

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state       <= IDLE;
            flush_q     <= 1'b0;
            noblend_q   <= 1'b0;
            load_adr_q  <= '0;
            o_memReq    <= 1'b0;
            o_memWrite  <= 1'b0;
            o_memAdr    <= '0;
            o_memMask   <= '0;
            clear_spike <= 1'b0;
            o_flushDone <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_newBlock) begin
                        flush_q    <= trig_flush;
                        noblend_q  <= i_noblend;
                        load_adr_q <= i_loadAdr;
                        o_memMask  <= i_mask;
                        o_busy     <= 1'b1;
                        if (trig_save) begin
                            state      <= SAVE;
                            o_memReq   <= 1'b1;
                            o_memWrite <= 1'b1;
                            o_memAdr   <= i_saveAdr;
                        end else if (!i_noblend && !trig_flush) begin
                            // pairCode 00/01 (or an empty-mask skip) enters the block without saving
                            state      <= LOAD;
                            o_memReq   <= 1'b1;
                            o_memWrite <= 1'b0;
                            o_memAdr   <= i_loadAdr;
                        end else begin
                            state       <= CLEAR;
                            clear_spike <= 1'b1;
                            o_flushDone <= trig_flush;
                        end
                    end
                end
                SAVE: begin
                    if (i_memAck) begin
                        if (flush_q || noblend_q) begin
                            state       <= CLEAR;
                            o_memReq    <= 1'b0;
                            o_memWrite  <= 1'b0;
                            clear_spike <= 1'b1;
                            o_flushDone <= flush_q;
                        end else begin
                            // load only after the save is acknowledged: it overwrites the shared cache
                            state      <= LOAD;
                            o_memWrite <= 1'b0;
                            o_memAdr   <= load_adr_q;
                        end
                    end
                end
                LOAD: begin
                    if (i_memAck) begin
                        state       <= CLEAR;
                        o_memReq    <= 1'b0;
                        clear_spike <= 1'b1;
                    end
                end
                CLEAR: begin
                    state       <= IDLE;
                    clear_spike <= 1'b0;
                    o_flushDone <= 1'b0;
                    o_busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_resetPipelinePixelStateSpike = clear_spike;
    assign o_resetPixelMask               = clear_spike;
    // in IDLE the pause must cover the trigger cycle itself, so it follows i_newBlock directly
    assign o_pausePipeline = (state != IDLE) || i_newBlock;
    assign o_importBG      = (state == LOAD) && i_memAck;

endmodule
